// File: rtl/integrate_dump_decim_if.sv
// Stream and control bundle for the integrate-and-dump decimator.
// The master side drives samples and configuration; the slave side returns dumped sums.
interface integrate_dump_decim_if #(
  parameter int CH_NUM         = 2,
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DATA_WIDTH_OUT = 40,
  parameter int RATIO_WIDTH    = 16
);
  logic [RATIO_WIDTH-1:0]                     ratio_i;
  logic                                       sync_i;
  logic                                       ovf_clr_i;
  logic                                       tvalid_i;
  logic [CH_NUM-1:0][DATA_WIDTH_IN-1:0]       tdata_i;
  logic                                       tvalid_o;
  logic [CH_NUM-1:0][DATA_WIDTH_OUT-1:0]      tdata_o;
  logic                                       ovf_o;

  modport master (
    output ratio_i, sync_i, ovf_clr_i, tvalid_i, tdata_i,
    input  tvalid_o, tdata_o, ovf_o
  );

  modport slave (
    input  ratio_i, sync_i, ovf_clr_i, tvalid_i, tdata_i,
    output tvalid_o, tdata_o, ovf_o
  );
endinterface

// File: rtl/integrate_dump_decim.sv
// Multichannel integrate-and-dump decimator.
// Sums R consecutive valid samples per channel (shared valid, counter and latched ratio)
// and emits one full-precision sum per period with a one-cycle valid pulse.
module integrate_dump_decim #(
  parameter int CH_NUM         = 2,
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DATA_WIDTH_OUT = 40,
  parameter int RATIO_WIDTH    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  integrate_dump_decim_if.slave bus
);

  localparam int MSB = DATA_WIDTH_OUT - 1;

  logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
  logic [RATIO_WIDTH-1:0] r_lat_q, r_lat_d;
  logic [RATIO_WIDTH-1:0] ratio_sane;
  logic [RATIO_WIDTH-1:0] r_eff;
  logic [RATIO_WIDTH-1:0] cnt_cur;
  logic                   start;
  logic                   dump;

  logic signed [DATA_WIDTH_OUT-1:0] acc_q [CH_NUM];
  logic signed [DATA_WIDTH_OUT-1:0] acc_d [CH_NUM];
  logic signed [DATA_WIDTH_OUT-1:0] xs    [CH_NUM];
  logic signed [DATA_WIDTH_OUT-1:0] base  [CH_NUM];
  logic signed [DATA_WIDTH_OUT-1:0] sum   [CH_NUM];
  logic [CH_NUM-1:0]                ovf_ch;

  logic [CH_NUM-1:0][DATA_WIDTH_OUT-1:0] tdata_q, tdata_d;
  logic tvalid_q, tvalid_d;
  logic ovf_q, ovf_d;

  // Period bookkeeping: a sync restarts the period as if cnt were already zero, so a
  // sample arriving alongside sync is treated as the first sample of a fresh period.
  always_comb begin
    ratio_sane = (bus.ratio_i == '0) ? RATIO_WIDTH'(1) : bus.ratio_i;
    start      = bus.sync_i || (cnt_q == '0);
    cnt_cur    = start ? '0 : cnt_q;
    r_eff      = start ? ratio_sane : r_lat_q;
    dump       = bus.tvalid_i && (cnt_cur == (r_eff - RATIO_WIDTH'(1)));
  end

  // Per-channel datapath: sign-extend, add onto the running sum (or restart), flag wraps.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      xs[c]     = DATA_WIDTH_OUT'($signed(bus.tdata_i[c]));
      base[c]   = start ? '0 : acc_q[c];
      sum[c]    = base[c] + xs[c];
      ovf_ch[c] = !start && (acc_q[c][MSB] == xs[c][MSB]) && (sum[c][MSB] != acc_q[c][MSB]);
    end
  end

  // Next-state for counter, ratio latch, accumulators, output registers and sticky flag.
  always_comb begin
    cnt_d    = cnt_q;
    r_lat_d  = r_lat_q;
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tvalid_d = 1'b0;
    if (bus.sync_i) begin
      cnt_d = '0;
    end
    if (bus.tvalid_i) begin
      if (start) begin
        r_lat_d = ratio_sane;
      end
      for (int c = 0; c < CH_NUM; c++) begin
        acc_d[c] = sum[c];
      end
      if (dump) begin
        cnt_d    = '0;
        tvalid_d = 1'b1;
        for (int c = 0; c < CH_NUM; c++) begin
          tdata_d[c] = sum[c];
        end
      end else begin
        cnt_d = cnt_cur + RATIO_WIDTH'(1);
      end
    end
    // A wrap in the same cycle as a clear must leave the flag set.
    ovf_d = (bus.tvalid_i && (|ovf_ch)) || (ovf_q && !bus.ovf_clr_i);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      r_lat_q  <= RATIO_WIDTH'(1);
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      r_lat_q  <= r_lat_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_d;
      for (int c = 0; c < CH_NUM; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  assign bus.tvalid_o = tvalid_q;
  assign bus.tdata_o  = tdata_q;
  assign bus.ovf_o    = ovf_q;

endmodule

// File: tb/tb_integrate_dump_decim.sv
// Bench for integrate_dump_decim: a full-width instance and a narrow (20-bit) instance
// receive identical stimulus and are checked against a period-level arithmetic model.
module tb_integrate_dump_decim;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  integrate_dump_decim_if #(.DATA_WIDTH_OUT(40)) bus_a ();
  integrate_dump_decim_if #(.DATA_WIDTH_OUT(20)) bus_b ();

  integrate_dump_decim #(.DATA_WIDTH_OUT(40)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
  integrate_dump_decim #(.DATA_WIDTH_OUT(20)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: index [dut][channel], dut 0 is 40-bit, dut 1 is 20-bit.
  int     W [2] = '{40, 20};
  longint m_acc [2][2];
  longint m_out [2][2];
  bit     m_ovf [2];
  bit     m_vout;
  int     m_cnt;
  int     m_rlat;

  logic [79:0] exp_a;
  logic [39:0] exp_b;
  int cur_ratio = 4;

  function automatic longint wrapw(longint v, int w);
    longint span = longint'(1) << w;
    longint half = span >> 1;
    while (v >= half) v -= span;
    while (v < -half) v += span;
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_rlat = 1; m_vout = 0;
    for (int d = 0; d < 2; d++) begin
      m_ovf[d] = 0;
      for (int c = 0; c < 2; c++) begin m_acc[d][c] = 0; m_out[d][c] = 0; end
    end
    exp_a = '0; exp_b = '0;
  endtask

  task automatic model_update(bit v, int x0, int x1, int ratio, bit sy, bit clr);
    int xv [2];
    bit setf [2];
    longint t;
    xv[0] = x0; xv[1] = x1;
    setf[0] = 0; setf[1] = 0;
    m_vout = 0;
    if (sy) m_cnt = 0;
    if (v) begin
      if (m_cnt == 0) begin
        m_rlat = (ratio == 0) ? 1 : ratio;
        for (int d = 0; d < 2; d++)
          for (int c = 0; c < 2; c++) m_acc[d][c] = xv[c];
      end else begin
        for (int d = 0; d < 2; d++)
          for (int c = 0; c < 2; c++) begin
            t = m_acc[d][c] + xv[c];
            if (t != wrapw(t, W[d])) setf[d] = 1;
            m_acc[d][c] = wrapw(t, W[d]);
          end
      end
      m_cnt++;
      if (m_cnt == m_rlat) begin
        m_vout = 1;
        m_cnt = 0;
        for (int d = 0; d < 2; d++)
          for (int c = 0; c < 2; c++) m_out[d][c] = m_acc[d][c];
      end
    end
    for (int d = 0; d < 2; d++) m_ovf[d] = setf[d] || (m_ovf[d] && !clr);
    exp_a = {40'(m_out[0][1]), 40'(m_out[0][0])};
    exp_b = {20'(m_out[1][1]), 20'(m_out[1][0])};
  endtask

  // One clock of stimulus to both instances; model advanced to the post-edge state.
  task automatic step(bit v, int x0, int x1, bit sy = 0, bit clr = 0);
    bus_a.tvalid_i = v;  bus_b.tvalid_i = v;
    bus_a.tdata_i[0] = 16'(x0); bus_b.tdata_i[0] = 16'(x0);
    bus_a.tdata_i[1] = 16'(x1); bus_b.tdata_i[1] = 16'(x1);
    bus_a.ratio_i = 16'(cur_ratio); bus_b.ratio_i = 16'(cur_ratio);
    bus_a.sync_i = sy;   bus_b.sync_i = sy;
    bus_a.ovf_clr_i = clr; bus_b.ovf_clr_i = clr;
    @(posedge clk);
    #1;
    model_update(v, x0, x1, cur_ratio, sy, clr);
  endtask

  task automatic test_reset();
    model_reset();
    step(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus_a.tvalid_o !== 1'b0 || bus_a.tdata_o !== 80'd0 || bus_a.ovf_o !== 1'b0 ||
        bus_b.tvalid_o !== 1'b0 || bus_b.tdata_o !== 40'd0 || bus_b.ovf_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: got v=%b d=%h o=%b want 0/0/0", bus_a.tvalid_o, bus_a.tdata_o, bus_a.ovf_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int pulses = 0;
    cur_ratio = 4;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) step(1, i, -1); else step(0, 0, 0);
      if (bus_a.tvalid_o === 1'b1) pulses++;
      tests_run++;
      if (bus_a.tvalid_o !== m_vout || bus_a.tdata_o !== exp_a) begin
        tests_failed++;
        $display("FAIL basic cyc%0d: got v=%b d=%h want v=%b d=%h", i, bus_a.tvalid_o, bus_a.tdata_o, m_vout, exp_a);
      end
      if (i == 4) begin
        tests_run++;
        if (bus_a.tvalid_o !== 1'b1 || bus_a.tdata_o !== {-40'sd4, 40'sd10}) begin
          tests_failed++;
          $display("FAIL basic_sum: got v=%b d=%h want 1 {-4,10}", bus_a.tvalid_o, bus_a.tdata_o);
        end
      end
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL basic_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_gaps();
    cur_ratio = 4;
    for (int i = 1; i <= 4; i++) begin
      for (int g = 0; g < int'($urandom_range(3)); g++) begin
        step(0, 99, 99);
        tests_run++;
        if (bus_a.tvalid_o !== m_vout || bus_a.tdata_o !== exp_a) begin
          tests_failed++;
          $display("FAIL gaps_idle: got v=%b d=%h want v=%b d=%h", bus_a.tvalid_o, bus_a.tdata_o, m_vout, exp_a);
        end
      end
      step(1, i, -1);
      tests_run++;
      if (bus_a.tvalid_o !== (i == 4) || bus_a.tdata_o !== exp_a) begin
        tests_failed++;
        $display("FAIL gaps_sample%0d: got v=%b d=%h want v=%b d=%h", i, bus_a.tvalid_o, bus_a.tdata_o, (i == 4), exp_a);
      end
    end
    tests_run++;
    if (bus_a.tdata_o !== {-40'sd4, 40'sd10}) begin
      tests_failed++;
      $display("FAIL gaps_sum: got %h want {-4,10}", bus_a.tdata_o);
    end
  endtask

  task automatic test_ratio_one_and_change();
    for (int r = 0; r <= 1; r++) begin
      cur_ratio = r;
      step(1, -32768, 5);
      tests_run++;
      if (bus_a.tvalid_o !== 1'b1 || bus_a.tdata_o[0] !== 40'hFF_FFFF_8000 || bus_a.tdata_o !== exp_a) begin
        tests_failed++;
        $display("FAIL ratio%0d: got v=%b d=%h want 1 %h", r, bus_a.tvalid_o, bus_a.tdata_o, exp_a);
      end
    end
    cur_ratio = 2;
    step(1, 10, 1);
    cur_ratio = 3;
    for (int i = 0; i < 4; i++) begin
      step(1, 20 + i, 2);
      tests_run++;
      if (bus_a.tvalid_o !== m_vout || bus_a.tdata_o !== exp_a) begin
        tests_failed++;
        $display("FAIL ratio_change%0d: got v=%b d=%h want v=%b d=%h", i, bus_a.tvalid_o, bus_a.tdata_o, m_vout, exp_a);
      end
    end
    // Old ratio 2 ends on the first of these samples (10+20=30); new ratio 3 ends on the 4th.
    tests_run++;
    if (bus_a.tvalid_o !== 1'b1 || bus_a.tdata_o[0] !== 40'd66) begin
      tests_failed++;
      $display("FAIL ratio_change_sum: got v=%b d=%0d want 1 66", bus_a.tvalid_o, bus_a.tdata_o[0]);
    end
  endtask

  task automatic test_sync();
    int pulses = 0;
    cur_ratio = 8;
    for (int i = 0; i < 5; i++) begin
      step(1, 100, 100);
      if (bus_a.tvalid_o === 1'b1) pulses++;
    end
    step(1, 7, 7, 1'b1);
    if (bus_a.tvalid_o === 1'b1) pulses++;
    for (int i = 0; i < 7; i++) begin
      step(1, 7, 7);
      if (bus_a.tvalid_o === 1'b1) pulses++;
      tests_run++;
      if (bus_a.tvalid_o !== m_vout || bus_a.tdata_o !== exp_a) begin
        tests_failed++;
        $display("FAIL sync%0d: got v=%b d=%h want v=%b d=%h", i, bus_a.tvalid_o, bus_a.tdata_o, m_vout, exp_a);
      end
    end
    tests_run++;
    if (pulses != 1 || bus_a.tdata_o[0] !== 40'd56) begin
      tests_failed++;
      $display("FAIL sync_sum: got pulses=%0d d=%0d want 1 56", pulses, bus_a.tdata_o[0]);
    end
  endtask

  task automatic test_overflow();
    cur_ratio = 32;
    step(0, 0, 0, 1'b1);
    for (int n = 1; n <= 49; n++) begin
      step(1, 32767, 0, 1'b0, (n == 40) || (n == 49));
      tests_run++;
      if (bus_b.ovf_o !== m_ovf[1] || bus_b.tvalid_o !== m_vout || bus_b.tdata_o !== exp_b ||
          bus_a.ovf_o !== m_ovf[0]) begin
        tests_failed++;
        $display("FAIL ovf_n%0d: got o=%b v=%b d=%h want o=%b v=%b d=%h", n, bus_b.ovf_o, bus_b.tvalid_o,
                 bus_b.tdata_o, m_ovf[1], m_vout, exp_b);
      end
      if (n == 16 || n == 17 || n == 40 || n == 49) begin
        tests_run++;
        if (bus_b.ovf_o !== (n != 16 && n != 40)) begin
          tests_failed++;
          $display("FAIL ovf_point%0d: got %b want %b", n, bus_b.ovf_o, (n != 16 && n != 40));
        end
      end
    end
  endtask

  task automatic test_random();
    int x0, x1;
    bit v, sy, clr;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) cur_ratio = $urandom_range(40);
      v   = ($urandom_range(9) < 7);
      sy  = ($urandom_range(39) == 0);
      clr = ($urandom_range(19) == 0);
      x0  = int'($urandom_range(65535)) - 32768;
      x1  = int'($urandom_range(65535)) - 32768;
      step(v, x0, x1, sy, clr);
      tests_run++;
      if (bus_a.tvalid_o !== m_vout || bus_a.tdata_o !== exp_a || bus_a.ovf_o !== m_ovf[0] ||
          bus_b.tvalid_o !== m_vout || bus_b.tdata_o !== exp_b || bus_b.ovf_o !== m_ovf[1]) begin
        tests_failed++;
        $display("FAIL random%0d: got a=%b/%h/%b b=%b/%h/%b want a=%b/%h/%b b=%h/%b", i,
                 bus_a.tvalid_o, bus_a.tdata_o, bus_a.ovf_o, bus_b.tvalid_o, bus_b.tdata_o, bus_b.ovf_o,
                 m_vout, exp_a, m_ovf[0], exp_b, m_ovf[1]);
      end
    end
  endtask

  task automatic test_async_reset();
    cur_ratio = 1;
    step(0, 0, 0, 1'b1);
    step(1, 9, 3);
    cur_ratio = 4;
    step(1, 5, 5);
    step(1, 5, 5);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if (bus_a.tvalid_o !== 1'b0 || bus_a.tdata_o !== 80'd0 || bus_a.ovf_o !== 1'b0 || bus_b.tdata_o !== 40'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b d=%h o=%b want 0/0/0", bus_a.tvalid_o, bus_a.tdata_o, bus_a.ovf_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1, 5, -5);
      tests_run++;
      if (bus_a.tvalid_o !== m_vout || bus_a.tdata_o !== exp_a) begin
        tests_failed++;
        $display("FAIL post_reset%0d: got v=%b d=%h want v=%b d=%h", i, bus_a.tvalid_o, bus_a.tdata_o, m_vout, exp_a);
      end
    end
    tests_run++;
    if (bus_a.tvalid_o !== 1'b1 || bus_a.tdata_o !== {-40'sd20, 40'sd20}) begin
      tests_failed++;
      $display("FAIL post_reset_sum: got v=%b d=%h want 1 {-20,20}", bus_a.tvalid_o, bus_a.tdata_o);
    end
  endtask

  initial begin
    bus_a.tvalid_i = 0; bus_a.tdata_i = '0; bus_a.ratio_i = '0; bus_a.sync_i = 0; bus_a.ovf_clr_i = 0;
    bus_b.tvalid_i = 0; bus_b.tdata_i = '0; bus_b.ratio_i = '0; bus_b.sync_i = 0; bus_b.ovf_clr_i = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_ratio_one_and_change();
    test_sync();
    test_overflow();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
